sample_tx_buffer: RTL and testbench

Buffers processed samples from the bit-changer stage and serializes each one into UART bytes for the UART transmitter. Sits between `bit_changer_seq` (`out_frame`/`out_ready`) and `uart_tx` (`i_Tx_DV`/`i_Tx_Byte`/`o_Tx_Active`/`o_Tx_Done`). Lets back-to-back samples arrive while the slow UART link is busy without losing data. A DEPTH-entry FIFO decouples the two sides, and a byte-serializer FSM drains it under the transmitter's busy/done handshake.

---
 rtl/sample_tx_buffer.sv | 188 ++++++++++++++++++
 tb/tb_sample_tx_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_tx_buffer.sv
// sample_tx_buffer: FIFO of BPS-bit samples drained LSB byte first into a
// UART transmitter through a start-strobe / busy / done handshake.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a queued sample and an idle transmitter; pops
// S_SEND      | byte ready in shift register, strobe once tx_busy is low
// S_WAIT_DONE | byte handed off, waiting for tx_done to advance or finish
module sample_tx_buffer #(
    parameter  int BPS   = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           in_clk,
    input  logic           in_rst,
    input  logic           in_sample_ready,
    input  logic [BPS-1:0] in_sample,
    input  logic           tx_busy,
    input  logic           tx_done,
    output logic [7:0]     out_uart_frame,
    output logic           out_ready,
    output logic           out_full,
    output logic           out_empty,
    output logic [AW:0]    out_count,
    output logic           out_overflow
);

    localparam int BYTES = BPS / 8;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [BPS-1:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    logic [BPS-1:0]   r_shift;
    logic [BIW-1:0]   r_byte_idx;
    logic [7:0]       r_frame;
    logic             r_ready;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr;
    logic             w_ovf;
    logic             w_last;
    logic             w_load;
    logic             w_strobe;
    logic             w_shift;

    // Occupancy decode from the authoritative count register
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_last  = (r_byte_idx == BIW'(BYTES - 1));

    // A pop only ever happens from IDLE, which lets a write at full proceed
    assign w_pop = (r_state == S_IDLE) && !w_empty && !tx_busy;
    assign w_wr  = in_sample_ready && (!w_full || w_pop);
    assign w_ovf = in_sample_ready && w_full && !w_pop;

    // Next occupancy for the count and the registered full/empty flags
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge in_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_sample;
        end
    end

    // FIFO pointers, count and registered status flags
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_overflow <= w_ovf;
        end
    end

    // Serializer state register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Serializer next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    w_state_nxt = w_last ? S_IDLE : S_SEND;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Serializer control decode
    always_comb begin
        w_load   = 1'b0;
        w_strobe = 1'b0;
        w_shift  = 1'b0;
        case (r_state)
            S_IDLE:      w_load   = w_pop;
            S_SEND:      w_strobe = !tx_busy;
            S_WAIT_DONE: w_shift  = tx_done && !w_last;
            default: ;
        endcase
    end

    // Shift register, byte index and registered transmitter outputs
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_frame    <= 8'h00;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= w_strobe;
            if (w_load) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_byte_idx <= '0;
            end else if (w_shift) begin
                r_shift    <= r_shift >> 8;
                r_byte_idx <= r_byte_idx + BIW'(1);
            end
            if (w_strobe) begin
                r_frame <= r_shift[7:0];
            end
        end
    end

    assign out_uart_frame = r_frame;
    assign out_ready      = r_ready;
    assign out_full       = r_full;
    assign out_empty      = r_empty;
    assign out_count      = r_count;
    assign out_overflow   = r_overflow;

endmodule

// File: tb/tb_sample_tx_buffer.sv
// Directed bench for sample_tx_buffer (BPS=16, DEPTH=4) with a simple UART
// transmitter model: busy for 10 cycles after each strobe, then a done pulse.
module tb_sample_tx_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sr = 1'b0;
    logic [15:0] smp = 16'h0000;
    logic        force_busy = 1'b0;
    logic        tx_busy;
    logic        m_done = 1'b0;
    int          busy_cnt = 0;

    logic [7:0]  out_uart_frame;
    logic        out_ready;
    logic        out_full;
    logic        out_empty;
    logic [2:0]  out_count;
    logic        out_overflow;

    int          n_tests = 0;
    int          n_fail = 0;
    int          viol = 0;
    logic [7:0]  q[$];

    sample_tx_buffer #(.BPS(16), .DEPTH(4)) dut (
        .in_clk          (clk),
        .in_rst          (rst),
        .in_sample_ready (sr),
        .in_sample       (smp),
        .tx_busy         (tx_busy),
        .tx_done         (m_done),
        .out_uart_frame  (out_uart_frame),
        .out_ready       (out_ready),
        .out_full        (out_full),
        .out_empty       (out_empty),
        .out_count       (out_count),
        .out_overflow    (out_overflow)
    );

    always #5 clk = ~clk;

    assign tx_busy = force_busy | (busy_cnt != 0);

    // UART model, deliberately not reset so a transfer in flight completes
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            busy_cnt <= 10;
        end
    end

    // Byte capture
    always @(negedge clk) begin
        if (out_ready) begin
            q.push_back(out_uart_frame);
            if (tx_busy) viol++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qat(input int i);
        return (i < q.size()) ? 32'(q[i]) : 32'hDEAD;
    endfunction

    initial begin
        int peak;
        logic [7:0] exp_c [6];
        logic [7:0] exp_e [10];
        exp_c = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55};
        exp_e = '{8'h01, 8'h0A, 8'h02, 8'h0A, 8'h03, 8'h0A, 8'h04, 8'h0A, 8'h06, 8'h0A};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_frame", 32'(out_uart_frame), 32'h00);
        check("rst_ready", 32'(out_ready), 32'h0);
        check("rst_full", 32'(out_full), 32'h0);
        check("rst_empty", 32'(out_empty), 32'h1);
        check("rst_count", 32'(out_count), 32'h0);
        check("rst_ovf", 32'(out_overflow), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single sample 0xA55A, latency and byte order
        q.delete();
        sr = 1'b1; smp = 16'hA55A;
        @(negedge clk);
        sr = 1'b0; smp = 16'h0000;
        check("single_count_after_wr", 32'(out_count), 32'h1);
        check("single_empty_after_wr", 32'(out_empty), 32'h0);
        @(negedge clk);
        check("single_no_early_ready", 32'(out_ready), 32'h0);
        check("single_count_after_pop", 32'(out_count), 32'h0);
        @(negedge clk);
        check("single_ready_latency", 32'(out_ready), 32'h1);
        check("single_low_byte", 32'(out_uart_frame), 32'h5A);
        for (int i = 0; i < 100 && q.size() < 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("single_nbytes", 32'(q.size()), 32'd2);
        check("single_byte0", qat(0), 32'h5A);
        check("single_byte1", qat(1), 32'hA5);
        check("single_empty_end", 32'(out_empty), 32'h1);

        // Ordering of three back-to-back samples
        q.delete();
        peak = 0;
        sr = 1'b1; smp = 16'h1122;
        @(negedge clk);
        smp = 16'h3344;
        @(negedge clk);
        smp = 16'h5566;
        @(negedge clk);
        sr = 1'b0; smp = 16'h0000;
        for (int i = 0; i < 400 && q.size() < 6; i++) begin
            @(negedge clk);
            if (int'(out_count) > peak) peak = int'(out_count);
        end
        repeat (20) @(negedge clk);
        check("order_nbytes", 32'(q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("order_byte%0d", i), qat(i), 32'(exp_c[i]));
        check("order_peak_count", 32'(peak), 32'd2);

        // Overflow with transmitter held busy
        q.delete();
        force_busy = 1'b1;
        @(negedge clk);
        sr = 1'b1; smp = 16'h0A01;
        @(negedge clk);
        smp = 16'h0A02;
        @(negedge clk);
        smp = 16'h0A03;
        @(negedge clk);
        smp = 16'h0A04;
        @(negedge clk);
        check("ovf_full_at4", 32'(out_full), 32'h1);
        check("ovf_count_at4", 32'(out_count), 32'd4);
        check("ovf_no_pulse_yet", 32'(out_overflow), 32'h0);
        smp = 16'h0A05;
        @(negedge clk);
        sr = 1'b0; smp = 16'h0000;
        check("ovf_pulse", 32'(out_overflow), 32'h1);
        check("ovf_count_held", 32'(out_count), 32'd4);
        @(negedge clk);
        check("ovf_pulse_one_cycle", 32'(out_overflow), 32'h0);
        check("ovf_no_tx_while_busy", 32'(q.size()), 32'd0);

        // Full with simultaneous pop and write
        force_busy = 1'b0;
        sr = 1'b1; smp = 16'h0A06;
        @(negedge clk);
        sr = 1'b0; smp = 16'h0000;
        check("fullrw_count", 32'(out_count), 32'd4);
        check("fullrw_no_ovf", 32'(out_overflow), 32'h0);
        check("fullrw_full", 32'(out_full), 32'h1);
        for (int i = 0; i < 800 && q.size() < 10; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check("fullrw_nbytes", 32'(q.size()), 32'd10);
        for (int i = 0; i < 10; i++) check($sformatf("fullrw_byte%0d", i), qat(i), 32'(exp_e[i]));
        check("fullrw_empty_end", 32'(out_empty), 32'h1);

        // Reset in the middle of a sample, asynchronous mid-cycle
        q.delete();
        sr = 1'b1; smp = 16'hBEEF;
        @(negedge clk);
        sr = 1'b0; smp = 16'h0000;
        for (int i = 0; i < 50 && q.size() < 1; i++) @(negedge clk);
        check("midrst_first_byte", qat(0), 32'hEF);
        repeat (2) @(negedge clk);
        check("midrst_frame_before", 32'(out_uart_frame), 32'hEF);
        #2 rst = 1'b1;
        #1;
        check("midrst_async_frame", 32'(out_uart_frame), 32'h00);
        check("midrst_async_ready", 32'(out_ready), 32'h0);
        check("midrst_async_empty", 32'(out_empty), 32'h1);
        check("midrst_async_count", 32'(out_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_more_bytes", 32'(q.size()), 32'd1);
        sr = 1'b1; smp = 16'h0102;
        @(negedge clk);
        sr = 1'b0; smp = 16'h0000;
        for (int i = 0; i < 100 && q.size() < 3; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("midrst_nbytes", 32'(q.size()), 32'd3);
        check("midrst_new_byte0", qat(1), 32'h02);
        check("midrst_new_byte1", qat(2), 32'h01);
        check("ready_never_busy", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
